// File: rtl/cu_vertex_cache_request_arbiter.sv
// Round-robin arbiter sharing the vertex-cache read-command port among compute-unit
// requesters, with tag allocation, tag-routed responses and a bounded in-flight pool.
module cu_vertex_cache_request_arbiter #(
    parameter int NUM_REQUESTERS  = 2,
    parameter int CMD_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 16,
    localparam int TAG_WIDTH = $clog2(MAX_OUTSTANDING),
    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1),
    localparam int OWN_WIDTH = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                clock,
    input  logic                                rstn_in,
    input  logic                                enabled_in,
    input  logic [NUM_REQUESTERS-1:0]           req_valid_in,
    input  logic [NUM_REQUESTERS*CMD_WIDTH-1:0] req_payload_in,
    output logic [NUM_REQUESTERS-1:0]           req_ready_out,
    output logic                                cmd_valid_out,
    output logic [CMD_WIDTH-1:0]                cmd_payload_out,
    output logic [TAG_WIDTH-1:0]                cmd_tag_out,
    input  logic                                cmd_ready_in,
    input  logic                                rsp_valid_in,
    input  logic [TAG_WIDTH-1:0]                rsp_tag_in,
    output logic [NUM_REQUESTERS-1:0]           rsp_valid_out,
    output logic [CNT_WIDTH-1:0]                outstanding_out,
    output logic                                idle_out,
    output logic                                tag_error_out
);

    logic [NUM_REQUESTERS-1:0] rr_ptr_q, rr_ptr_d;
    logic [MAX_OUTSTANDING-1:0] tag_busy_q, tag_busy_d;
    logic [OWN_WIDTH-1:0]       tag_owner_q [MAX_OUTSTANDING];
    logic                       cmd_valid_q, cmd_valid_d;
    logic [CMD_WIDTH-1:0]       cmd_payload_q, cmd_payload_d;
    logic [TAG_WIDTH-1:0]       cmd_tag_q, cmd_tag_d;
    logic [NUM_REQUESTERS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [CNT_WIDTH-1:0]       outstanding_q, outstanding_d;
    logic                       idle_q, idle_d;
    logic                       tag_error_q, tag_error_d;

    logic                       can_grant_s, grant_found_s, grant_s, rsp_hit_s;
    logic [OWN_WIDTH-1:0]       cand_s, grant_idx_s;
    logic [CMD_WIDTH-1:0]       grant_payload_s;
    logic [TAG_WIDTH-1:0]       alloc_tag_s;
    logic [NUM_REQUESTERS-1:0]  req_ready_s;

    // Arbitration, tag selection and next-state computation
    always_comb begin
        // Gated by reset so no grant is ever signalled while the block is held in reset.
        can_grant_s = rstn_in && enabled_in && (!cmd_valid_q || cmd_ready_in)
                      && (|(~tag_busy_q));
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand_s = OWN_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQUESTERS);
            if (!grant_found_s && req_valid_in[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_s = can_grant_s && grant_found_s;

        grant_payload_s = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_idx_s == OWN_WIDTH'(i)) begin
                grant_payload_s = req_payload_in[i*CMD_WIDTH +: CMD_WIDTH];
            end else begin
                grant_payload_s = grant_payload_s;
            end
        end

        // Descending scan leaves the lowest free index; uses the pre-free bitmap.
        alloc_tag_s = '0;
        for (int t = MAX_OUTSTANDING - 1; t >= 0; t--) begin
            if (!tag_busy_q[t]) begin
                alloc_tag_s = TAG_WIDTH'(t);
            end else begin
                alloc_tag_s = alloc_tag_s;
            end
        end

        req_ready_s = '0;
        if (grant_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end

        rsp_hit_s   = rsp_valid_in && tag_busy_q[rsp_tag_in];
        tag_error_d = tag_error_q || (rsp_valid_in && !tag_busy_q[rsp_tag_in]);
        rsp_valid_d = '0;
        tag_busy_d  = tag_busy_q;
        if (rsp_hit_s) begin
            rsp_valid_d[tag_owner_q[rsp_tag_in]] = 1'b1;
            tag_busy_d[rsp_tag_in]               = 1'b0;
        end else begin
            rsp_valid_d = '0;
        end

        rr_ptr_d      = rr_ptr_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_payload_d = cmd_payload_q;
        cmd_tag_d     = cmd_tag_q;
        if (grant_s) begin
            tag_busy_d[alloc_tag_s] = 1'b1;
            rr_ptr_d      = NUM_REQUESTERS'((int'(grant_idx_s) + 1) % NUM_REQUESTERS);
            cmd_valid_d   = 1'b1;
            cmd_payload_d = grant_payload_s;
            cmd_tag_d     = alloc_tag_s;
        end else if (cmd_ready_in) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end

        case ({grant_s, rsp_hit_s})
            2'b10:   outstanding_d = outstanding_q + CNT_WIDTH'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_WIDTH'(1);
            default: outstanding_d = outstanding_q;
        endcase

        idle_d = (outstanding_d == '0) && !cmd_valid_d;
    end

    // State and output registers
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            rr_ptr_q      <= '0;
            tag_busy_q    <= '0;
            for (int t = 0; t < MAX_OUTSTANDING; t++) begin
                tag_owner_q[t] <= '0;
            end
            cmd_valid_q   <= 1'b0;
            cmd_payload_q <= '0;
            cmd_tag_q     <= '0;
            rsp_valid_q   <= '0;
            outstanding_q <= '0;
            idle_q        <= 1'b1;
            tag_error_q   <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            tag_busy_q    <= tag_busy_d;
            if (grant_s) begin
                tag_owner_q[alloc_tag_s] <= grant_idx_s;
            end
            cmd_valid_q   <= cmd_valid_d;
            cmd_payload_q <= cmd_payload_d;
            cmd_tag_q     <= cmd_tag_d;
            rsp_valid_q   <= rsp_valid_d;
            outstanding_q <= outstanding_d;
            idle_q        <= idle_d;
            tag_error_q   <= tag_error_d;
        end
    end

    assign req_ready_out   = req_ready_s;
    assign cmd_valid_out   = cmd_valid_q;
    assign cmd_payload_out = cmd_payload_q;
    assign cmd_tag_out     = cmd_tag_q;
    assign rsp_valid_out   = rsp_valid_q;
    assign outstanding_out = outstanding_q;
    assign idle_out        = idle_q;
    assign tag_error_out   = tag_error_q;

endmodule
